de2i_150_sysid_ext: RTL



---
 rtl/sysid_pkg.sv | 28 ++
 rtl/sysid_uptime_counter.sv | 51 +++++
 rtl/de2i_150_sysid_ext.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the de2i_150 system-ID peripheral: word map, CTRL bit
// positions and the byte-lane write merge used by the RW registers.
package sysid_pkg;

   localparam logic [2:0] ADDR_ID      = 3'd0;
   localparam logic [2:0] ADDR_TS      = 3'd1;
   localparam logic [2:0] ADDR_UPLO    = 3'd2;
   localparam logic [2:0] ADDR_UPHI    = 3'd3;
   localparam logic [2:0] ADDR_SCRATCH = 3'd4;
   localparam logic [2:0] ADDR_CTRL    = 3'd5;
   localparam logic [2:0] ADDR_HBDIV   = 3'd6;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_CLR = 1;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with enable/clear and a shadow that captures the
// upper word whenever the lower word is read, giving a tear-free 64-bit read.
module sysid_uptime_counter
   import sysid_pkg::*;
#(
   parameter int          CNT_W      = 64,
   parameter logic [63:0] CNT_PRESET = 64'd0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        clear,
   input  logic        latch,
   output logic [31:0] count_lo,
   output logic [31:0] shadow
);

   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [31:0]      count_hi;

   // Upper bits zero-extended to a full word; CNT_W is at least 33.
   assign count_hi = 32'(count_q >> 32);

   // Clear beats both enable and a simultaneous low-word read.
   always_comb begin
      count_d  = count_q;
      shadow_d = shadow_q;
      if (clear) begin
         count_d  = '0;
         shadow_d = '0;
      end else begin
         if (enable) count_d = count_q + CNT_W'(1);
         if (latch)  shadow_d = count_hi;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= CNT_PRESET[CNT_W-1:0];
         shadow_q <= '0;
      end else begin
         count_q  <= count_d;
         shadow_q <= shadow_d;
      end
   end

   assign count_lo = count_q[31:0];
   assign shadow   = shadow_q;

endmodule

// File: rtl/de2i_150_sysid_ext.sv
// Avalon-MM system-ID slave: fixed ID/timestamp, uptime counter with atomic
// readback, scratch register, and a programmable heartbeat square wave.
module de2i_150_sysid_ext
   import sysid_pkg::*;
#(
   parameter logic [31:0] SYSTEM_ID    = 32'h5317_0001,
   parameter logic [31:0] TIMESTAMP    = 32'd1394063533,
   parameter int          CNT_W        = 64,
   parameter logic [31:0] HB_DIV_RESET = 32'd25_000_000,
   // Reset value of the uptime counter; left at 0 except for simulation.
   parameter logic [63:0] CNT_PRESET   = 64'd0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid,
   output logic        heartbeat
);

   logic [31:0] scratch_q, scratch_d;
   logic        en_q, en_d;
   logic [31:0] hb_div_q, hb_div_d;
   logic [31:0] presc_q, presc_d;
   logic        hb_q, hb_d;
   logic [31:0] readdata_q, readdata_d;
   logic        rdvalid_q, rdvalid_d;
   logic        clear_pulse;
   logic        hb_div_wr;
   logic        latch_hi;
   logic [31:0] count_lo;
   logic [31:0] shadow;
   logic [31:0] rd_word;

   sysid_uptime_counter #(
      .CNT_W      (CNT_W),
      .CNT_PRESET (CNT_PRESET)
   ) u_uptime (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (en_q),
      .clear    (clear_pulse),
      .latch    (latch_hi),
      .count_lo (count_lo),
      .shadow   (shadow)
   );

   assign latch_hi  = read && (address == ADDR_UPLO);
   assign hb_div_wr = write && (address == ADDR_HBDIV);

   always_comb begin
      scratch_d   = scratch_q;
      en_d        = en_q;
      hb_div_d    = hb_div_q;
      clear_pulse = 1'b0;
      if (write) begin
         case (address)
            ADDR_SCRATCH: scratch_d = be_merge(scratch_q, writedata, byteenable);
            ADDR_CTRL: begin
               if (byteenable[0]) begin
                  en_d        = writedata[CTRL_EN];
                  clear_pulse = writedata[CTRL_CLR];
               end
            end
            ADDR_HBDIV:   hb_div_d = be_merge(hb_div_q, writedata, byteenable);
            default: ;
         endcase
      end
   end

   // Read mux sees pre-edge register values, so a same-cycle write is not visible.
   always_comb begin
      rd_word = 32'd0;
      case (address)
         ADDR_ID:      rd_word = SYSTEM_ID;
         ADDR_TS:      rd_word = TIMESTAMP;
         ADDR_UPLO:    rd_word = count_lo;
         ADDR_UPHI:    rd_word = shadow;
         ADDR_SCRATCH: rd_word = scratch_q;
         ADDR_CTRL:    rd_word = {31'd0, en_q};
         ADDR_HBDIV:   rd_word = hb_div_q;
         default:      rd_word = 32'd0;
      endcase
      readdata_d = read ? rd_word : readdata_q;
      rdvalid_d  = read;
   end

   // A divider of 0 parks the heartbeat low; a divider write restarts the period.
   always_comb begin
      presc_d = presc_q;
      hb_d    = hb_q;
      if (hb_div_q == 32'd0) begin
         presc_d = 32'd0;
         hb_d    = 1'b0;
      end else if (hb_div_wr) begin
         presc_d = 32'd0;
      end else if (presc_q >= hb_div_q) begin
         presc_d = 32'd0;
         hb_d    = ~hb_q;
      end else begin
         presc_d = presc_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch_q  <= 32'd0;
         en_q       <= 1'b1;
         hb_div_q   <= HB_DIV_RESET;
         presc_q    <= 32'd0;
         hb_q       <= 1'b0;
         readdata_q <= 32'd0;
         rdvalid_q  <= 1'b0;
      end else begin
         scratch_q  <= scratch_d;
         en_q       <= en_d;
         hb_div_q   <= hb_div_d;
         presc_q    <= presc_d;
         hb_q       <= hb_d;
         readdata_q <= readdata_d;
         rdvalid_q  <= rdvalid_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdvalid_q;
   assign heartbeat     = hb_q;

endmodule
